// File: rtl/axi4_reg_slice.sv
// AXI4 register slice: one independently configurable slice per channel
// (AW, W, B, AR, R). Each slice is a bypass, a forward register, or a
// 2-entry skid buffer. Payloads are opaque packed vectors to the slice.

// Generic valid/ready slice used by every channel.
//   MODE 0: bypass wires, no state.
//   MODE 2: forward register; in_ready depends combinationally on out_ready.
//   MODE 1 (and any other value): 2-entry skid buffer with registered in_ready.
module axi4_reg_slice_chan #(
    parameter int PW   = 8,
    parameter int MODE = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] in_pl,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [PW-1:0] out_pl
);

    if (MODE == 0) begin : g_bypass
        // No state in bypass; clock and reset are intentionally unused.
        logic unused_clk_rst;
        assign unused_clk_rst = clock ^ reset;

        assign out_valid = in_valid;
        assign out_pl    = in_pl;
        assign in_ready  = out_ready;

    end else if (MODE == 2) begin : g_forward
        logic          valid_q;
        logic [PW-1:0] pl_q;
        logic          in_fire;
        logic          out_fire;

        // Accept whenever the register is free or is being drained this cycle.
        assign in_ready  = (~valid_q | out_ready) & ~reset;
        assign out_valid = valid_q;
        assign out_pl    = pl_q;
        assign in_fire   = in_valid & in_ready;
        assign out_fire  = valid_q & out_ready;

        // Load on every accepted beat; drop valid only when drained with nothing new.
        always_ff @(posedge clock) begin
            // NOTE: the payload register is reset as well, so out_pl reads zero
            // after reset instead of whatever was in flight; it only adds reset fanout.
            if (reset) begin
                valid_q <= 1'b0;
                pl_q    <= '0;
            end else if (in_fire) begin
                valid_q <= 1'b1;
                pl_q    <= in_pl;
            end else if (out_fire) begin
                valid_q <= 1'b0;
            end
        end

    end else begin : g_skid
        typedef enum logic [1:0] {
            EMPTY = 2'd0,
            ONE   = 2'd1,
            FULL  = 2'd2
        } state_t;

        state_t        state_q;
        state_t        state_d;
        logic          ready_q;
        logic [PW-1:0] main_q;
        logic [PW-1:0] skid_q;
        logic          load_main_in;
        logic          load_main_skid;
        logic          load_skid;
        logic          in_fire;
        logic          out_fire;

        // in_ready comes straight from a flop (gated only by reset), so there is
        // no combinational path from out_ready or in_valid to in_ready.
        assign in_ready  = ready_q & ~reset;
        assign out_valid = (state_q != EMPTY);
        assign out_pl    = main_q;
        assign in_fire   = in_valid & in_ready;
        assign out_fire  = out_valid & out_ready;

        // Next-state and register load selection.
        always_comb begin
            // NOTE: every output of this block gets a default before the case,
            // and blocking '=' is used here, so no latch can be inferred.
            state_d        = state_q;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d      = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state_d   = FULL;
                        load_skid = 1'b1;
                    end else if (out_fire && !in_fire) begin
                        state_d = EMPTY;
                    end else if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        state_d        = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end

        // State register plus the registered copy of "not full" that drives in_ready.
        always_ff @(posedge clock) begin
            // NOTE: sequential state is written with non-blocking '<=' only.
            if (reset) begin
                state_q <= EMPTY;
                ready_q <= 1'b1;
            end else begin
                state_q <= state_d;
                ready_q <= (state_d != FULL);
            end
        end

        // Main and skid payload registers.
        always_ff @(posedge clock) begin
            if (reset) begin
                main_q <= '0;
                skid_q <= '0;
            end else begin
                if (load_main_in) begin
                    main_q <= in_pl;
                end else if (load_main_skid) begin
                    main_q <= skid_q;
                end
                if (load_skid) begin
                    skid_q <= in_pl;
                end
            end
        end
    end

endmodule

// Top: five independent channel slices. AW/W/AR flow s_ -> m_, B/R flow m_ -> s_.
module axi4_reg_slice #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int AW_MODE = 1,
    parameter int W_MODE  = 1,
    parameter int B_MODE  = 1,
    parameter int AR_MODE = 1,
    parameter int R_MODE  = 1,
    localparam int AW_PW  = ID_W + ADDR_W + 13,
    localparam int AR_PW  = ID_W + ADDR_W + 13,
    localparam int W_PW   = DATA_W + DATA_W / 8 + 1,
    localparam int B_PW   = ID_W + 2,
    localparam int R_PW   = ID_W + DATA_W + 3
) (
    input  logic             clock,
    input  logic             reset,

    input  logic             s_awvalid,
    output logic             s_awready,
    input  logic [AW_PW-1:0] s_awpl,
    output logic             m_awvalid,
    input  logic             m_awready,
    output logic [AW_PW-1:0] m_awpl,

    input  logic             s_wvalid,
    output logic             s_wready,
    input  logic [W_PW-1:0]  s_wpl,
    output logic             m_wvalid,
    input  logic             m_wready,
    output logic [W_PW-1:0]  m_wpl,

    output logic             s_bvalid,
    input  logic             s_bready,
    output logic [B_PW-1:0]  s_bpl,
    input  logic             m_bvalid,
    output logic             m_bready,
    input  logic [B_PW-1:0]  m_bpl,

    input  logic             s_arvalid,
    output logic             s_arready,
    input  logic [AR_PW-1:0] s_arpl,
    output logic             m_arvalid,
    input  logic             m_arready,
    output logic [AR_PW-1:0] m_arpl,

    output logic             s_rvalid,
    input  logic             s_rready,
    output logic [R_PW-1:0]  s_rpl,
    input  logic             m_rvalid,
    output logic             m_rready,
    input  logic [R_PW-1:0]  m_rpl
);

    axi4_reg_slice_chan #(.PW(AW_PW), .MODE(AW_MODE)) u_aw (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (s_awvalid),
        .in_ready  (s_awready),
        .in_pl     (s_awpl),
        .out_valid (m_awvalid),
        .out_ready (m_awready),
        .out_pl    (m_awpl)
    );

    axi4_reg_slice_chan #(.PW(W_PW), .MODE(W_MODE)) u_w (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (s_wvalid),
        .in_ready  (s_wready),
        .in_pl     (s_wpl),
        .out_valid (m_wvalid),
        .out_ready (m_wready),
        .out_pl    (m_wpl)
    );

    axi4_reg_slice_chan #(.PW(B_PW), .MODE(B_MODE)) u_b (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (m_bvalid),
        .in_ready  (m_bready),
        .in_pl     (m_bpl),
        .out_valid (s_bvalid),
        .out_ready (s_bready),
        .out_pl    (s_bpl)
    );

    axi4_reg_slice_chan #(.PW(AR_PW), .MODE(AR_MODE)) u_ar (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (s_arvalid),
        .in_ready  (s_arready),
        .in_pl     (s_arpl),
        .out_valid (m_arvalid),
        .out_ready (m_arready),
        .out_pl    (m_arpl)
    );

    axi4_reg_slice_chan #(.PW(R_PW), .MODE(R_MODE)) u_r (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (m_rvalid),
        .in_ready  (m_rready),
        .in_pl     (m_rpl),
        .out_valid (s_rvalid),
        .out_ready (s_rready),
        .out_pl    (s_rpl)
    );

endmodule

// File: tb/tb_axi4_reg_slice.sv
// Bench for axi4_reg_slice. Three instances share one clock/reset:
//   d0: AW/W/AR/R skid buffers, B forward register
//   d1: every channel forward register
//   d2: every channel bypass
// A negedge monitor keeps, per channel, a queue of beats accepted but not
// yet delivered and derives the expected valid/ready/payload from its depth.
module tb_axi4_reg_slice;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;
    localparam int AW_PW  = ID_W + ADDR_W + 13;
    localparam int AR_PW  = ID_W + ADDR_W + 13;
    localparam int W_PW   = DATA_W + DATA_W / 8 + 1;
    localparam int B_PW   = ID_W + 2;
    localparam int R_PW   = ID_W + DATA_W + 3;
    localparam int NK     = 3;
    localparam int NC     = 5;   // 0 AW, 1 W, 2 B, 3 AR, 4 R
    localparam int SOAK_CYCLES = 10000;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // "src" is the side feeding the slice, "dst" the side it drives.
    logic        src_valid [NK][NC];
    logic [63:0] src_pl    [NK][NC];
    logic        dst_ready [NK][NC];
    wire         src_ready [NK][NC];
    wire         dst_valid [NK][NC];
    wire  [63:0] dst_pl    [NK][NC];

    int n_checks = 0;
    int n_errors = 0;

    logic        in_fired   [NK][NC];
    logic        stall_prev [NK*NC];
    logic [63:0] prev_pl    [NK*NC];
    logic [63:0] model_q    [NK*NC][$];

    function automatic int mode_of(input int k, input int c);
        if (k == 2) return 0;
        if (k == 1) return 2;
        return (c == 2) ? 2 : 1;
    endfunction

    function automatic int pw_of(input int c);
        case (c)
            0:       return AW_PW;
            1:       return W_PW;
            2:       return B_PW;
            3:       return AR_PW;
            default: return R_PW;
        endcase
    endfunction

    function automatic logic [63:0] pw_mask(input int c);
        return (64'd1 << pw_of(c)) - 64'd1;
    endfunction

    function automatic string chan_name(input int i);
        string ch [NC] = '{"aw", "w", "b", "ar", "r"};
        return $sformatf("d%0d.%s", i / NC, ch[i % NC]);
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar k = 0; k < NK; k++) begin : g_dut
        logic [AW_PW-1:0] m_awpl;
        logic [W_PW-1:0]  m_wpl;
        logic [B_PW-1:0]  s_bpl;
        logic [AR_PW-1:0] m_arpl;
        logic [R_PW-1:0]  s_rpl;

        axi4_reg_slice #(
            .ADDR_W  (ADDR_W),
            .DATA_W  (DATA_W),
            .ID_W    (ID_W),
            .AW_MODE (k == 0 ? 1 : (k == 1 ? 2 : 0)),
            .W_MODE  (k == 0 ? 1 : (k == 1 ? 2 : 0)),
            .B_MODE  (k == 2 ? 0 : 2),
            .AR_MODE (k == 0 ? 1 : (k == 1 ? 2 : 0)),
            .R_MODE  (k == 0 ? 1 : (k == 1 ? 2 : 0))
        ) u_dut (
            .clock     (clock),
            .reset     (reset),
            .s_awvalid (src_valid[k][0]),
            .s_awready (src_ready[k][0]),
            .s_awpl    (src_pl[k][0][AW_PW-1:0]),
            .m_awvalid (dst_valid[k][0]),
            .m_awready (dst_ready[k][0]),
            .m_awpl    (m_awpl),
            .s_wvalid  (src_valid[k][1]),
            .s_wready  (src_ready[k][1]),
            .s_wpl     (src_pl[k][1][W_PW-1:0]),
            .m_wvalid  (dst_valid[k][1]),
            .m_wready  (dst_ready[k][1]),
            .m_wpl     (m_wpl),
            .s_bvalid  (dst_valid[k][2]),
            .s_bready  (dst_ready[k][2]),
            .s_bpl     (s_bpl),
            .m_bvalid  (src_valid[k][2]),
            .m_bready  (src_ready[k][2]),
            .m_bpl     (src_pl[k][2][B_PW-1:0]),
            .s_arvalid (src_valid[k][3]),
            .s_arready (src_ready[k][3]),
            .s_arpl    (src_pl[k][3][AR_PW-1:0]),
            .m_arvalid (dst_valid[k][3]),
            .m_arready (dst_ready[k][3]),
            .m_arpl    (m_arpl),
            .s_rvalid  (dst_valid[k][4]),
            .s_rready  (dst_ready[k][4]),
            .s_rpl     (s_rpl),
            .m_rvalid  (src_valid[k][4]),
            .m_rready  (src_ready[k][4]),
            .m_rpl     (src_pl[k][4][R_PW-1:0])
        );

        assign dst_pl[k][0] = 64'(m_awpl);
        assign dst_pl[k][1] = 64'(m_wpl);
        assign dst_pl[k][2] = 64'(s_bpl);
        assign dst_pl[k][3] = 64'(m_arpl);
        assign dst_pl[k][4] = 64'(s_rpl);
    end

    // Reference model: bypass channels must mirror their input; buffered
    // channels hold the accepted-but-undelivered beats in a FIFO, with
    // capacity 2 (skid, ready registered) or 1 (forward, ready passes through).
    always @(negedge clock) begin
        for (int k = 0; k < NK; k++) begin
            for (int c = 0; c < NC; c++) begin
                automatic int          i    = k * NC + c;
                automatic int          m    = mode_of(k, c);
                automatic string       nm   = chan_name(i);
                automatic logic        iv   = src_valid[k][c];
                automatic logic        ir   = src_ready[k][c];
                automatic logic        ov   = dst_valid[k][c];
                automatic logic        ordy = dst_ready[k][c];
                automatic logic [63:0] ipl  = src_pl[k][c];
                automatic logic [63:0] opl  = dst_pl[k][c];
                automatic int          sz   = model_q[i].size();
                automatic logic        exp_ready;

                if (m == 0) begin
                    check({nm, "/byp_valid"}, 64'(ov), 64'(iv));
                    check({nm, "/byp_ready"}, 64'(ir), 64'(ordy));
                    check({nm, "/byp_pl"}, opl, ipl);
                    in_fired[k][c] <= iv & ir;
                end else begin
                    check({nm, "/valid"}, 64'(ov), 64'(sz > 0));
                    if (sz > 0) check({nm, "/pl"}, opl, model_q[i][0]);
                    if (reset) begin
                        check({nm, "/rst_ready"}, 64'(ir), 64'd0);
                        model_q[i].delete();
                        stall_prev[i]  <= 1'b0;
                        in_fired[k][c] <= 1'b0;
                    end else begin
                        exp_ready = (m == 1) ? (sz < 2) : (sz == 0 || ordy);
                        check({nm, "/ready"}, 64'(ir), 64'(exp_ready));
                        if (stall_prev[i]) begin
                            check({nm, "/hold_valid"}, 64'(ov), 64'd1);
                            check({nm, "/hold_pl"}, opl, prev_pl[i]);
                        end
                        if (ov && ordy && sz > 0) void'(model_q[i].pop_front());
                        if (iv && ir) model_q[i].push_back(ipl);
                        stall_prev[i]  <= ov & ~ordy;
                        prev_pl[i]     <= opl;
                        in_fired[k][c] <= iv & ir;
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [AW_PW-1:0] ax_beat(input int id, input logic [31:0] addr);
        return {ID_W'(id), ADDR_W'(addr), 8'd0, 3'd2, 2'd1};
    endfunction

    function automatic logic [W_PW-1:0] w_beat(input logic [31:0] data);
        return {DATA_W'(data), 4'hF, 1'b1};
    endfunction

    function automatic logic [R_PW-1:0] r_beat(input int n);
        return {ID_W'(1), DATA_W'(32'hC0DE_0000 + n), 2'b00, (n == 7)};
    endfunction

    initial begin
        int sent;
        int recv;
        logic stalled;

        for (int k = 0; k < NK; k++) begin
            for (int c = 0; c < NC; c++) begin
                src_valid[k][c] = 1'b0;
                src_pl[k][c]    = '0;
                dst_ready[k][c] = 1'b0;
            end
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // First cycle after reset.
        @(negedge clock);
        check("post_rst_awready", 64'(src_ready[0][0]), 64'd1);
        check("post_rst_bready",  64'(src_ready[0][2]), 64'd1);
        check("post_rst_awvalid", 64'(dst_valid[0][0]), 64'd0);

        // Skid AW: four back-to-back addresses, one cycle of latency.
        dst_ready[0][0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (i < 4) begin
                src_valid[0][0] = 1'b1;
                src_pl[0][0]    = 64'(ax_beat(i, 32'h1000 + 4 * i));
            end else begin
                src_valid[0][0] = 1'b0;
            end
            @(negedge clock);
            if (i < 4) check("t1_awready", 64'(src_ready[0][0]), 64'd1);
            if (i == 0 || i == 5) begin
                check("t1_awvalid_idle", 64'(dst_valid[0][0]), 64'd0);
            end else begin
                check("t1_awvalid", 64'(dst_valid[0][0]), 64'd1);
                check("t1_awaddr", 64'(dst_pl[0][0][ADDR_W+12:13]), 64'(32'h1000 + 4 * (i - 1)));
            end
        end

        // Skid W: downstream stalled, third beat refused, then all drain in order.
        dst_ready[0][1] = 1'b0;
        step(); src_valid[0][1] = 1'b1; src_pl[0][1] = 64'(w_beat(32'hA0A0_0001));
        @(negedge clock); check("t2_wready_a", 64'(src_ready[0][1]), 64'd1);
        step(); src_pl[0][1] = 64'(w_beat(32'hA0A0_0002));
        @(negedge clock); check("t2_wready_b", 64'(src_ready[0][1]), 64'd1);
        step(); src_pl[0][1] = 64'(w_beat(32'hA0A0_0003));
        @(negedge clock);
        check("t2_wready_full", 64'(src_ready[0][1]), 64'd0);
        check("t2_wdata_a_held", 64'(dst_pl[0][1][W_PW-1:5]), 64'h0A0A0_0001);
        step(); dst_ready[0][1] = 1'b1;
        @(negedge clock);
        check("t2_wready_still_full", 64'(src_ready[0][1]), 64'd0);
        check("t2_wdata_a", 64'(dst_pl[0][1][W_PW-1:5]), 64'h0A0A0_0001);
        step();
        @(negedge clock);
        check("t2_wready_c", 64'(src_ready[0][1]), 64'd1);
        check("t2_wdata_b", 64'(dst_pl[0][1][W_PW-1:5]), 64'h0A0A0_0002);
        step(); src_valid[0][1] = 1'b0;
        @(negedge clock);
        check("t2_wvalid_c", 64'(dst_valid[0][1]), 64'd1);
        check("t2_wdata_c", 64'(dst_pl[0][1][W_PW-1:5]), 64'h0A0A0_0003);
        step();
        @(negedge clock);
        check("t2_wvalid_empty", 64'(dst_valid[0][1]), 64'd0);

        // Skid R: constant valid upstream, downstream ready toggling 1010...
        sent    = 0;
        recv    = 0;
        stalled = 1'b0;
        for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
            step();
            dst_ready[0][4] = (cyc % 2 == 0);
            src_valid[0][4] = (sent < 8);
            src_pl[0][4]    = 64'(r_beat(sent));
            @(negedge clock);
            if (stalled) check("t3_rvalid_held", 64'(dst_valid[0][4]), 64'd1);
            if (dst_valid[0][4] && dst_ready[0][4]) begin
                check("t3_rdata", 64'(dst_pl[0][4][DATA_W+2:3]), 64'(32'hC0DE_0000 + recv));
                check("t3_rlast", 64'(dst_pl[0][4][0]), 64'(recv == 7));
                recv++;
            end
            if (src_valid[0][4] && src_ready[0][4]) sent++;
            stalled = dst_valid[0][4] & ~dst_ready[0][4];
        end
        src_valid[0][4] = 1'b0;
        check("t3_beat_count", 64'(recv), 64'd8);

        // Forward B: held response stalls upstream, released with no bubble.
        dst_ready[0][2] = 1'b0;
        step(); src_valid[0][2] = 1'b1; src_pl[0][2] = 64'({4'd3, 2'b10});
        @(negedge clock); check("t4_bready_empty", 64'(src_ready[0][2]), 64'd1);
        step(); src_pl[0][2] = 64'({4'd5, 2'b00});
        @(negedge clock);
        check("t4_bready_stalled", 64'(src_ready[0][2]), 64'd0);
        check("t4_bvalid", 64'(dst_valid[0][2]), 64'd1);
        check("t4_bpl", dst_pl[0][2], 64'h0E);
        step();
        @(negedge clock);
        check("t4_bready_stalled2", 64'(src_ready[0][2]), 64'd0);
        check("t4_bpl_stable", dst_pl[0][2], 64'h0E);
        step(); dst_ready[0][2] = 1'b1;
        @(negedge clock);
        check("t4_bready_same_cycle", 64'(src_ready[0][2]), 64'd1);
        check("t4_bpl_drain", dst_pl[0][2], 64'h0E);
        step(); src_valid[0][2] = 1'b0;
        @(negedge clock);
        check("t4_bvalid_next", 64'(dst_valid[0][2]), 64'd1);
        check("t4_bpl_next", dst_pl[0][2], 64'h14);
        step();
        @(negedge clock);
        check("t4_bvalid_empty", 64'(dst_valid[0][2]), 64'd0);

        // Skid AR filled, then reset: buffered beats must vanish.
        dst_ready[0][3] = 1'b0;
        step(); src_valid[0][3] = 1'b1; src_pl[0][3] = 64'(ax_beat(2, 32'h2000));
        @(negedge clock); check("t5_arready_0", 64'(src_ready[0][3]), 64'd1);
        step(); src_pl[0][3] = 64'(ax_beat(2, 32'h2004));
        @(negedge clock); check("t5_arready_1", 64'(src_ready[0][3]), 64'd1);
        step(); src_valid[0][3] = 1'b0;
        @(negedge clock);
        check("t5_arready_full", 64'(src_ready[0][3]), 64'd0);
        check("t5_arvalid_full", 64'(dst_valid[0][3]), 64'd1);
        step(); reset = 1'b1;
        @(negedge clock); check("t5_arready_in_rst", 64'(src_ready[0][3]), 64'd0);
        step();
        @(negedge clock);
        check("t5_arvalid_rst", 64'(dst_valid[0][3]), 64'd0);
        check("t5_arready_rst", 64'(src_ready[0][3]), 64'd0);
        check("t5_arpl_rst", dst_pl[0][3], 64'd0);
        step(); reset = 1'b0; dst_ready[0][3] = 1'b1;
        @(negedge clock);
        check("t5_arready_after", 64'(src_ready[0][3]), 64'd1);
        check("t5_arvalid_after", 64'(dst_valid[0][3]), 64'd0);
        repeat (3) step();
        @(negedge clock);
        check("t5_no_stale", 64'(dst_valid[0][3]), 64'd0);

        // Random soak on every channel of every instance; the monitor checks.
        for (int cyc = 0; cyc < SOAK_CYCLES; cyc++) begin
            step();
            for (int k = 0; k < NK; k++) begin
                for (int c = 0; c < NC; c++) begin
                    if (!(src_valid[k][c] && !in_fired[k][c])) begin
                        src_valid[k][c] = ($urandom_range(0, 3) != 0);
                        src_pl[k][c]    = {$urandom, $urandom} & pw_mask(c);
                    end
                    dst_ready[k][c] = (cyc < SOAK_CYCLES / 2) ? ($urandom_range(0, 3) != 0)
                                                              : ($urandom_range(0, 3) == 0);
                end
            end
        end

        // Drain: stop sources once their current beat is taken, open every sink.
        for (int cyc = 0; cyc < 8; cyc++) begin
            step();
            for (int k = 0; k < NK; k++) begin
                for (int c = 0; c < NC; c++) begin
                    if (!(src_valid[k][c] && !in_fired[k][c])) src_valid[k][c] = 1'b0;
                    dst_ready[k][c] = 1'b1;
                end
            end
        end
        @(negedge clock);
        for (int k = 0; k < NK; k++) begin
            for (int c = 0; c < NC; c++) begin
                check({chan_name(k * NC + c), "/drained"}, 64'(dst_valid[k][c]), 64'd0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
